// File: rtl/if_pkg.sv
// Shared constants and FSM state type for the instruction-fetch stage.
package if_pkg;
  localparam int PC_LEN   = 16;
  localparam int INST_LEN = 16;
  localparam logic [INST_LEN-1:0] NOP_INST = 16'h0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } if_state_e;
endpackage

// File: rtl/if_fifo.sv
// Prefetch buffer: circular FIFO with push, pop, synchronous clear, count and head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: credit-limited prefetch into if_fifo, branch redirect with DRAIN.
// Optional macro IF_PERF_CNT_EN adds the saturating perf_bubble_cnt output.
module if_stage
  import if_pkg::*;
#(
  parameter logic [PC_LEN-1:0] RESET_PC   = 16'h0000,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hazard_detected,
  input  logic                br_taken,
  input  logic [PC_LEN-1:0]   br_addr,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [PC_LEN-1:0]   imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [INST_LEN-1:0] imem_rsp_data,
  output logic [INST_LEN-1:0] instruction,
  output logic [PC_LEN-1:0]   pc_out,
  output logic                inst_valid,
  output logic                o_dbg_state
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0]         perf_bubble_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = PC_LEN + INST_LEN;

  // Handshake: a request transfers on a cycle where imem_req_valid && imem_req_ready;
  // responses come back in order with no backpressure, one per imem_rsp_valid cycle.

  if_state_e         r_state;
  if_state_e         w_next_state;
  logic [PC_LEN-1:0] r_fetch_pc;
  logic [PC_LEN-1:0] r_rsp_pc;
  logic [CW-1:0]     r_in_flight;
  logic [CW-1:0]     w_in_flight_next;
  logic [CW-1:0]     w_fifo_count;
  logic [EW-1:0]     w_fifo_head;
  logic              w_fifo_empty;
  logic              w_credit_ok;
  logic              w_req_fire;
  logic              w_rsp_acc;
  logic              w_push;
  logic              w_pop;

  assign w_credit_ok    = (32'(r_in_flight) + 32'(w_fifo_count)) < 32'(FIFO_DEPTH);
  // Gated by rst_n so the request channel is idle while reset is asserted.
  assign imem_req_valid = rst_n && (r_state == ST_FETCH) && w_credit_ok;
  assign imem_addr      = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  // With nothing in flight a response cannot be legitimate (e.g. right after reset).
  assign w_rsp_acc      = imem_rsp_valid && (r_in_flight != '0);
  assign w_push         = w_rsp_acc && (r_state == ST_FETCH) && !br_taken;
  assign w_pop          = !w_fifo_empty && !hazard_detected && !br_taken;

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (br_taken),
    .i_data  ({r_rsp_pc, imem_rsp_data}),
    .o_head  (w_fifo_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty)
  );

  assign inst_valid  = !w_fifo_empty;
  assign instruction = w_fifo_empty ? NOP_INST : w_fifo_head[INST_LEN-1:0];
  assign pc_out      = w_fifo_empty ? '0 : w_fifo_head[EW-1:INST_LEN];
  assign o_dbg_state = r_state;

  always_comb begin
    w_next_state     = r_state;
    w_in_flight_next = r_in_flight + CW'(w_req_fire) - CW'(w_rsp_acc);
    if (br_taken) begin
      w_next_state = (w_in_flight_next != '0) ? ST_DRAIN : ST_FETCH;
    end else begin
      unique case (r_state)
        ST_FETCH: w_next_state = ST_FETCH;
        ST_DRAIN: w_next_state = (w_in_flight_next == '0) ? ST_FETCH : ST_DRAIN;
        default:  w_next_state = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_next_state;
  end

  // r_rsp_pc is the PC of the oldest in-flight request, valid because responses are in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_rsp_pc    <= RESET_PC;
      r_in_flight <= '0;
    end else begin
      r_in_flight <= w_in_flight_next;
      if (br_taken) begin
        r_fetch_pc <= br_addr;
        r_rsp_pc   <= br_addr;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + PC_LEN'(1);
        if (w_push)     r_rsp_pc   <= r_rsp_pc + PC_LEN'(1);
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (!inst_valid && !hazard_detected && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign perf_bubble_cnt = r_bubble_cnt;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: startup vector table, directed hazard/branch/wrap/reset sequences,
// then randomized traffic checked every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_if_stage;
  localparam int          DEPTH  = 2;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hazard_detected = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_addr = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [15:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data = '0;
  logic [15:0] instruction;
  logic [15:0] pc_out;
  logic        inst_valid;
  logic        o_dbg_state;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_bubble_cnt;
`endif

  if_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hazard_detected (hazard_detected),
    .br_taken        (br_taken),
    .br_addr         (br_addr),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instruction     (instruction),
    .pc_out          (pc_out),
    .inst_valid      (inst_valid),
    .o_dbg_state     (o_dbg_state)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model state ----------------
  typedef struct packed { logic [15:0] addr; logic dropped; } out_t;  // outstanding request
  typedef struct packed { logic [15:0] pc; logic [15:0] data; } ent_t; // buffered instruction
  typedef struct { logic [15:0] addr; int due; } mreq_t;               // memory-side request

  out_t  m_out[$];
  ent_t  m_fifo[$];
  mreq_t mem_q[$];
  logic [15:0] m_pc;
  int m_bub;
  int cyc;
  int last_due;
  int lat_lo = 1;
  int lat_hi = 1;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: never
  int n_chk = 0;
  int n_pass = 0;

  function automatic bit m_reqv();
    bit any_drop = 1'b0;
    foreach (m_out[i]) if (m_out[i].dropped) any_drop = 1'b1;
    return rst_n && !any_drop && ((m_out.size() + m_fifo.size()) < DEPTH);
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_outputs();
    ent_t h;
    chk("inst_valid", 32'(inst_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      h = m_fifo[0];
      chk("pc_out", 32'(pc_out), 32'(h.pc));
      chk("instruction", 32'(instruction), 32'(h.data));
    end else begin
      chk("nop_inst", 32'(instruction), 32'h0);
    end
    chk("req_valid", 32'(imem_req_valid), 32'(m_reqv()));
    if (m_reqv()) chk("imem_addr", 32'(imem_addr), 32'(m_pc));
`ifdef IF_PERF_CNT_EN
    chk("perf_cnt", 32'(perf_bubble_cnt), 32'(m_bub));
`endif
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic tick(input bit hz, input bit br, input logic [15:0] ba, input bit spur);
    bit rdy, rv, real_rsp, fire_dut, fire_m, pop, acc;
    logic [15:0] rd;
    out_t o;
    int due;
    check_outputs();
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = 1'($urandom_range(0, 1));
      default: rdy = 1'b0;
    endcase
    real_rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rv = real_rsp || spur;
    rd = real_rsp ? (mem_q[0].addr + 16'h1000) : 16'($urandom);
    hazard_detected = hz;
    br_taken        = br;
    br_addr         = ba;
    imem_req_ready  = rdy;
    imem_rsp_valid  = rv;
    imem_rsp_data   = rd;
    fire_dut = imem_req_valid && rdy;
    if (real_rsp) void'(mem_q.pop_front());
    if (fire_dut) begin
      due = cyc + $urandom_range(lat_lo, lat_hi);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mem_q.push_back('{imem_addr, due});
    end
    fire_m = m_reqv() && rdy;
    acc    = rv && (m_out.size() > 0);
    pop    = (m_fifo.size() > 0) && !hz && !br;
`ifdef IF_PERF_CNT_EN
    if ((m_fifo.size() == 0) && !hz && (m_bub < 65535)) m_bub++;
`endif
    if (pop) void'(m_fifo.pop_front());
    if (acc) begin
      o = m_out.pop_front();
      if (!o.dropped && !br) m_fifo.push_back('{o.addr, rd});
    end
    if (fire_m) begin
      m_out.push_back('{m_pc, 1'b0});
      m_pc = m_pc + 16'd1;
    end
    if (br) begin
      m_fifo.delete();
      foreach (m_out[i]) m_out[i].dropped = 1'b1;
      m_pc = ba;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_instruction", 32'(instruction), 32'h0);
    chk("rst_pc_out", 32'(pc_out), 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_state", 32'(o_dbg_state), 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("rst_perf", 32'(perf_bubble_cnt), 32'h0);
`endif
    hazard_detected = 1'b0;
    br_taken        = 1'b0;
    imem_rsp_valid  = 1'b0;
    m_out.delete();
    m_fifo.delete();
    mem_q.delete();
    m_pc = RST_PC;
    m_bub = 0;
    last_due = cyc;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- startup vector table ----------------
  typedef struct {
    bit          spur;
    bit          e_valid;
    logic [15:0] e_pc;
    bit          e_reqv;
    logic [15:0] e_addr;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int g;
    int ndrop;
    tbl[0] = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h0};
    tbl[1] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h1};
    tbl[2] = '{1'b0, 1'b1, 16'h0, 1'b0, 16'h0};
    tbl[3] = '{1'b0, 1'b1, 16'h1, 1'b1, 16'h2};
    tbl[4] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h3};
    tbl[5] = '{1'b0, 1'b1, 16'h2, 1'b0, 16'h0};
    tbl[6] = '{1'b0, 1'b1, 16'h3, 1'b1, 16'h4};
    tbl[7] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h5};
    tbl[8] = '{1'b0, 1'b1, 16'h4, 1'b0, 16'h0};
    cyc = 0;
    @(negedge clk);

    // Startup with a 1-cycle memory; a stray response in the first cycle must be ignored.
    rdy_mode = 0; lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      chk("tbl_valid", 32'(inst_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_valid) begin
        chk("tbl_pc", 32'(pc_out), 32'(tbl[i].e_pc));
        chk("tbl_inst", 32'(instruction), 32'(tbl[i].e_pc + 16'h1000));
      end
      chk("tbl_reqv", 32'(imem_req_valid), 32'(tbl[i].e_reqv));
      if (tbl[i].e_reqv) chk("tbl_addr", 32'(imem_addr), 32'(tbl[i].e_addr));
      tick(1'b0, 1'b0, 16'h0, tbl[i].spur);
    end

    // Hazard held for 5 cycles while pc_out=3.
    do_reset();
    g = 0;
    while (!(inst_valid && pc_out == 16'h3) && g < 20) begin tick(0, 0, 0, 0); g++; end
    chk("hz_reach_pc3_timeout", 32'(g < 20), 32'h1);
    for (int k = 0; k < 5; k++) begin
      chk("hz_pc_hold", 32'(pc_out), 32'h3);
      chk("hz_inst_hold", 32'(instruction), 32'h1003);
      tick(1, 0, 0, 0);
    end
    chk("hz_req_drop", 32'(imem_req_valid), 32'h0);
    tick(0, 0, 0, 0);
    chk("hz_resume_pc", 32'(pc_out), 32'h4);

    // Redirect with two requests outstanding on a 3-cycle memory.
    lat_lo = 3; lat_hi = 3;
    do_reset();
    g = 0;
    while (mem_q.size() != 2 && g < 10) begin tick(0, 0, 0, 0); g++; end
    chk("br_two_outstanding", 32'(mem_q.size()), 32'h2);
    tick(0, 1, 16'h0040, 0);
    ndrop = 0; g = 0;
    while (mem_q.size() > 0 && g < 20) begin
      chk("drain_no_req", 32'(imem_req_valid), 32'h0);
      chk("drain_no_inst", 32'(inst_valid), 32'h0);
      if (mem_q[0].due <= cyc) ndrop++;
      tick(0, 0, 0, 0); g++;
    end
    chk("drain_dropped", 32'(ndrop), 32'h2);
    g = 0;
    while (!inst_valid && g < 20) begin tick(0, 0, 0, 0); g++; end
    chk("br_target_pc", 32'(pc_out), 32'h0040);

    // Branch and hazard together: flush wins.
    lat_lo = 1; lat_hi = 1;
    chk("brhz_pre_valid", 32'(inst_valid), 32'h1);
    tick(1, 1, 16'h0100, 0);
    chk("brhz_flush", 32'(inst_valid), 32'h0);
    g = 0;
    while (!inst_valid && g < 20) begin tick(0, 0, 0, 0); g++; end
    chk("brhz_target_pc", 32'(pc_out), 32'h0100);

    // Fetch address wraps from 16'hFFFF to 16'h0000.
    tick(0, 1, 16'hFFFE, 0);
    g = 0;
    while (!(imem_req_valid && imem_addr == 16'hFFFF) && g < 20) begin tick(0, 0, 0, 0); g++; end
    chk("wrap_seen_ffff", 32'(g < 20), 32'h1);
    tick(0, 0, 0, 0);
    g = 0;
    while (!imem_req_valid && g < 20) begin tick(0, 0, 0, 0); g++; end
    chk("wrap_addr", 32'(imem_addr), 32'h0000);

    // Reset pulsed while draining.
    lat_lo = 3; lat_hi = 3;
    g = 0;
    while (mem_q.size() != 2 && g < 20) begin tick(0, 0, 0, 0); g++; end
    tick(0, 1, 16'h0200, 0);
    chk("drain_state", 32'(o_dbg_state), 32'h1);
    do_reset();
    chk("restart_req", 32'(imem_req_valid), 32'h1);
    chk("restart_addr", 32'(imem_addr), 32'(RST_PC));

`ifdef IF_PERF_CNT_EN
    // Memory stalled for 10 cycles after reset: every cycle is a bubble.
    rdy_mode = 2;
    do_reset();
    for (int k = 0; k < 10; k++) tick(0, 0, 0, 0);
    chk("perf_stall10", 32'(perf_bubble_cnt), 32'd10);
`endif

    // Randomized traffic against the reference model.
    rdy_mode = 1; lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 800; n++) begin
      bit hz, br;
      logic [15:0] ba;
      hz = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 19) == 0);
      ba = ($urandom_range(0, 1) == 0) ? 16'($urandom) : (16'hFFFC + 16'($urandom_range(0, 3)));
      if (n == 400) do_reset();
      tick(hz, br, ba, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
